// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
//   RESET_PC  - PC after reset (kernel mode)
//   ILLOP_PC  - interrupt vector
//   XADR_PC   - address-error vector
//   fetch_state_t - fetch FSM state encoding
package mips_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
   localparam logic [31:0] XADR_PC  = 32'h8000_0008;

   typedef enum logic {
      FS_REQ  = 1'b0,
      FS_HOLD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response port.
//   req   - fetch request, held until ack
//   addr  - fetch address
//   ack   - response valid, meaningful only while req=1
//   rdata - instruction word, valid with ack
// master: fetch stage side; slave: memory side.
interface if_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the architectural PC, fetches the word at PC
// over a variable-latency memory port and holds it until downstream consumes it.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   NextPC              - next PC from the PC-select stage
//   Advance             - consume current instruction (only while InstValid)
//   IRQ                 - level interrupt request
//   imem                - instruction-memory port (master)
//   PC, PCPlus4         - current PC and its sequential successor
//   Instruction         - held instruction word
//   InstValid           - Instruction/PC pair valid
//   IRQTaken, AddrErr   - one-cycle pulses aligned with the newly loaded PC
//
// state   | meaning
// FS_REQ  | request outstanding at PC, waiting for ack
// FS_HOLD | instruction held, waiting for Advance
module if_fetch
   import mips_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         NextPC,
   input  logic                Advance,
   input  logic                IRQ,
   if_fetch_if.master          imem,
   output logic [31:0]         PC,
   output logic [31:0]         PCPlus4,
   output logic [31:0]         Instruction,
   output logic                InstValid,
   output logic                IRQTaken,
   output logic                AddrErr
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         irq_pend_q, irq_pend_d;
   logic         irq_taken_q, irq_taken_d;
   logic         addr_err_q, addr_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FS_REQ;
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0;
         irq_pend_q  <= 1'b0;
         irq_taken_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         irq_pend_q  <= irq_pend_d;
         irq_taken_q <= irq_taken_d;
         addr_err_q  <= addr_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      irq_pend_d  = irq_pend_q | IRQ;
      irq_taken_d = 1'b0;
      addr_err_d  = 1'b0;
      case (state_q)
         FS_REQ: begin
            if (imem.ack) begin
               instr_d = imem.rdata;
               state_d = FS_HOLD;
            end
         end
         FS_HOLD: begin
            if (Advance) begin
               state_d = FS_REQ;
               // Interrupts are only taken from user mode; a request raised in
               // this same cycle stays pending for a later Advance.
               if (irq_pend_q && !pc_q[31]) begin
                  pc_d        = ILLOP_PC;
                  irq_taken_d = 1'b1;
                  irq_pend_d  = IRQ;
               end else if (NextPC[1:0] != 2'b00) begin
                  pc_d       = XADR_PC;
                  addr_err_d = 1'b1;
               end else begin
                  pc_d = NextPC;
               end
            end
         end
         default: state_d = FS_REQ;
      endcase
   end

   assign imem.req    = (state_q == FS_REQ) && !reset;
   assign imem.addr   = pc_q;
   assign PC          = pc_q;
   // Mode bit is preserved; the address part wraps within its 2 GiB half.
   assign PCPlus4     = {pc_q[31], pc_q[30:0] + 31'd4};
   assign Instruction = instr_q;
   assign InstValid   = (state_q == FS_HOLD);
   assign IRQTaken    = irq_taken_q;
   assign AddrErr     = addr_err_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] NextPC;
   logic        Advance;
   logic        IRQ;
   logic [31:0] PC, PCPlus4, Instruction;
   logic        InstValid, IRQTaken, AddrErr;

   int n_checks = 0;
   int n_errors = 0;

   if_fetch_if imem ();

   if_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .NextPC      (NextPC),
      .Advance     (Advance),
      .IRQ         (IRQ),
      .imem        (imem.master),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .Instruction (Instruction),
      .InstValid   (InstValid),
      .IRQTaken    (IRQTaken),
      .AddrErr     (AddrErr)
   );

   always #5 clk = ~clk;

   // irq_mode: 0 none, 1 IRQ pulse in HOLD before Advance, 2 IRQ with Advance
   typedef struct {
      logic [1:0]  irq_mode;
      logic [31:0] next_pc;
      logic [31:0] exp_pc;
      logic [31:0] exp_plus4;
      logic        exp_irq;
      logic        exp_aerr;
   } vec_t;

   vec_t vecs [16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Serve the outstanding request after 'delay' idle cycles, with spurious
   // Advance asserted while waiting.
   task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
      for (int d = 0; d < delay; d++) begin
         Advance = 1'b1;
         step();
         chk("wait_req", {31'h0, imem.req}, 32'h1);
         chk("wait_addr", imem.addr, exp_addr);
         chk("wait_pc", PC, exp_addr);
         chk("wait_pulses", {30'h0, IRQTaken, AddrErr}, 32'h0);
      end
      Advance    = 1'b0;
      imem.ack   = 1'b1;
      imem.rdata = word;
      chk("ack_addr", imem.addr, exp_addr);
      step();
      imem.ack   = 1'b0;
      chk("fetch_valid", {31'h0, InstValid}, 32'h1);
      chk("fetch_instr", Instruction, word);
      chk("fetch_pc", PC, exp_addr);
      chk("fetch_pulses", {30'h0, IRQTaken, AddrErr}, 32'h0);
   endtask

   initial begin
      vecs[0]  = '{2'd0, 32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 1'b0, 1'b0};
      vecs[1]  = '{2'd0, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
      vecs[2]  = '{2'd0, 32'h0040_0010, 32'h0040_0010, 32'h0040_0014, 1'b0, 1'b0};
      vecs[3]  = '{2'd0, 32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 1'b0, 1'b0};
      vecs[4]  = '{2'd1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
      vecs[5]  = '{2'd0, 32'h0040_0020, 32'h8000_0004, 32'h8000_0008, 1'b1, 1'b0};
      vecs[6]  = '{2'd0, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
      vecs[7]  = '{2'd0, 32'h0040_0002, 32'h8000_0008, 32'h8000_000C, 1'b0, 1'b1};
      vecs[8]  = '{2'd0, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
      vecs[9]  = '{2'd1, 32'h0040_0002, 32'h8000_0004, 32'h8000_0008, 1'b1, 1'b0};
      vecs[10] = '{2'd0, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h0000_0000, 1'b0, 1'b0};
      vecs[11] = '{2'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h8000_0000, 1'b0, 1'b0};
      vecs[12] = '{2'd0, 32'h8000_0001, 32'h8000_0008, 32'h8000_000C, 1'b0, 1'b1};
      vecs[13] = '{2'd0, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
      vecs[14] = '{2'd2, 32'h0040_0004, 32'h0040_0004, 32'h0040_0008, 1'b0, 1'b0};
      vecs[15] = '{2'd0, 32'h0040_0008, 32'h8000_0004, 32'h8000_0008, 1'b1, 1'b0};

      reset      = 1'b1;
      NextPC     = 32'h0;
      Advance    = 1'b0;
      IRQ        = 1'b0;
      imem.ack   = 1'b1;
      imem.rdata = 32'hDEAD_BEEF;
      step();
      step();
      chk("rst_pc", PC, 32'h8000_0000);
      chk("rst_valid", {31'h0, InstValid}, 32'h0);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_req", {31'h0, imem.req}, 32'h0);
      chk("rst_pulses", {30'h0, IRQTaken, AddrErr}, 32'h0);

      reset    = 1'b0;
      imem.ack = 1'b0;
      #1;
      chk("first_req", {31'h0, imem.req}, 32'h1);
      chk("first_addr", imem.addr, 32'h8000_0000);
      serve(32'h8000_0000, 32'h2408_0005, 0);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].irq_mode == 2'd1) begin
            IRQ = 1'b1;
            step();
            IRQ = 1'b0;
         end
         NextPC  = vecs[i].next_pc;
         Advance = 1'b1;
         IRQ     = (vecs[i].irq_mode == 2'd2);
         step();
         Advance = 1'b0;
         IRQ     = 1'b0;
         chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
         chk($sformatf("v%0d_plus4", i), PCPlus4, vecs[i].exp_plus4);
         chk($sformatf("v%0d_irqtaken", i), {31'h0, IRQTaken}, {31'h0, vecs[i].exp_irq});
         chk($sformatf("v%0d_addrerr", i), {31'h0, AddrErr}, {31'h0, vecs[i].exp_aerr});
         chk($sformatf("v%0d_req", i), {31'h0, imem.req}, 32'h1);
         chk($sformatf("v%0d_addr", i), imem.addr, vecs[i].exp_pc);
         chk($sformatf("v%0d_valid", i), {31'h0, InstValid}, 32'h0);
         serve(vecs[i].exp_pc, 32'h1000_0000 + i, i % 4);
      end

      // Reset while a fetch is outstanding; a late ack during reset is ignored.
      NextPC  = 32'h0040_0100;
      Advance = 1'b1;
      step();
      Advance = 1'b0;
      chk("mid_pc", PC, 32'h0040_0100);
      reset = 1'b1;
      step();
      chk("mid_rst_pc", PC, 32'h8000_0000);
      chk("mid_rst_req", {31'h0, imem.req}, 32'h0);
      imem.ack   = 1'b1;
      imem.rdata = 32'hBAD0_BAD0;
      step();
      chk("late_ack_valid", {31'h0, InstValid}, 32'h0);
      chk("late_ack_instr", Instruction, 32'h0);
      reset    = 1'b0;
      imem.ack = 1'b0;
      #1;
      chk("restart_req", {31'h0, imem.req}, 32'h1);
      chk("restart_addr", imem.addr, 32'h8000_0000);
      serve(32'h8000_0000, 32'h0000_0000, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
